// File: rtl/if_id_stage_ctrl_pkg.sv
// Shared front-end pipeline constants and the run/halt state encoding
// used by the IF/ID stage controller.
package if_id_stage_ctrl_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam logic [PC_W-1:0]    PC_INCR   = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } run_state_e;

endpackage

// File: rtl/if_id_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage_ctrl.sv
// Front-end pipeline control: owns the PC and IF/ID register, applies
// stall/redirect/halt, drives the ID/EX bubble and keeps event counters.
module if_id_stage_ctrl #(
  parameter int                          PC_W     = if_id_stage_ctrl_pkg::PC_W,
  parameter int                          INSTR_W  = if_id_stage_ctrl_pkg::INSTR_W,
  parameter int                          CNT_W    = 16,
  parameter logic [PC_W-1:0]             RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush_idex,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               idex_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               halted
);

  import if_id_stage_ctrl_pkg::*;

  run_state_e      state_q;
  run_state_e      state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus4;
  logic            running;
  logic            stall_inc;
  logic            flush_inc;

  assign running  = (state_q == RUN);
  assign pc_plus4 = pc_q + PC_W'(PC_INCR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A halt request is only honoured when no stall or redirect outranks it.
  always_comb begin
    state_d = state_q;
    if (running && !stall && !branch_taken && halt) begin
      state_d = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      if_id_instr    <= INSTR_W'(NOP_INSTR);
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (running && !stall) begin
      if (branch_taken) begin
        pc_q           <= branch_target;
        if_id_instr    <= INSTR_W'(NOP_INSTR);
        if_id_pc_plus4 <= '0;
        if_id_valid    <= 1'b0;
      end else if (halt) begin
        if_id_instr    <= INSTR_W'(NOP_INSTR);
        if_id_pc_plus4 <= '0;
        if_id_valid    <= 1'b0;
      end else begin
        pc_q           <= pc_plus4;
        if_id_instr    <= imem_instr;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
    end
  end

  // Stall plus flush_idex collapses to a single bubble; a branch hidden
  // behind a stall is not a flush event.
  assign idex_bubble = (stall | flush_idex) & running & ~reset;
  assign stall_inc   = running & stall;
  assign flush_inc   = running & ((branch_taken & ~stall) | flush_idex);

  assign pc_out = pc_q;
  assign halted = (state_q == HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Self-checking bench for if_id_stage_ctrl: directed scenarios plus a random
// phase, all compared each cycle against a behavioural model.
module tb_if_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush_idex = 1'b0;
  logic        branch_taken = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] branch_target = '0;
  logic        const_mode = 1'b1;

  logic [31:0] pc_a, instr_a, pc4_a, imem_a;
  logic        valid_a, bubble_a, halted_a;
  logic [15:0] scnt_a, fcnt_a;

  logic [31:0] pc_b, instr_b, pc4_b, imem_b;
  logic        valid_b, bubble_b, halted_b;
  logic [1:0]  scnt_b, fcnt_b;

  int tests = 0;
  int failed = 0;
  bit check_en = 1'b0;

  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_halted;
  int          m_stall16, m_flush16, m_stall2, m_flush2;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed word, or a scrambled function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic cm);
    if (cm) return 32'h8C220004;
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  assign imem_a = mem_fn(pc_a, const_mode);
  assign imem_b = mem_fn(pc_b, const_mode);

  if_id_stage_ctrl #(.PC_W(32), .INSTR_W(32), .CNT_W(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_idex(flush_idex),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .imem_instr(imem_a), .pc_out(pc_a), .if_id_instr(instr_a),
    .if_id_pc_plus4(pc4_a), .if_id_valid(valid_a), .idex_bubble(bubble_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a), .halted(halted_a)
  );

  if_id_stage_ctrl #(.PC_W(32), .INSTR_W(32), .CNT_W(2), .RESET_PC(32'h0)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush_idex(flush_idex),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .imem_instr(imem_b), .pc_out(pc_b), .if_id_instr(instr_b),
    .if_id_pc_plus4(pc4_b), .if_id_valid(valid_b), .idex_bubble(bubble_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b), .halted(halted_b)
  );

  // Reference model: applies the priority rules directly to abstract state.
  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_halted <= 1'b0; m_stall16 <= 0; m_flush16 <= 0; m_stall2 <= 0; m_flush2 <= 0;
    end else if (!m_halted) begin
      if (stall) begin
        m_stall16 <= sat(m_stall16, 65535);
        m_stall2  <= sat(m_stall2, 3);
      end
      if ((!stall && branch_taken) || flush_idex) begin
        m_flush16 <= sat(m_flush16, 65535);
        m_flush2  <= sat(m_flush2, 3);
      end
      if (!stall) begin
        if (branch_taken) begin
          m_pc <= branch_target; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
        end else if (halt) begin
          m_halted <= 1'b1; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
        end else begin
          m_pc <= m_pc + 32'd4; m_pc4 <= m_pc + 32'd4;
          m_instr <= mem_fn(m_pc, const_mode); m_valid <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("pc", pc_a, m_pc);
      checkOutput("if_id_instr", instr_a, m_instr);
      checkOutput("if_id_pc_plus4", pc4_a, m_pc4);
      checkOutput("if_id_valid", {31'b0, valid_a}, {31'b0, m_valid});
      checkOutput("halted", {31'b0, halted_a}, {31'b0, m_halted});
      checkOutput("idex_bubble", {31'b0, bubble_a},
                  {31'b0, (stall | flush_idex) & ~m_halted & ~reset});
      checkOutput("stall_cnt", {16'b0, scnt_a}, m_stall16);
      checkOutput("flush_cnt", {16'b0, fcnt_a}, m_flush16);
      checkOutput("pc_small", pc_b, m_pc);
      checkOutput("stall_cnt_small", {30'b0, scnt_b}, m_stall2);
      checkOutput("flush_cnt_small", {30'b0, fcnt_b}, m_flush2);
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic bt, input logic [31:0] tgt, input logic h);
    reset = r; stall = s; flush_idex = f; branch_taken = bt; branch_target = tgt; halt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    tick(); tick();
    check_en = 1'b1;
    checkOutput("rst_pc", pc_a, 32'h0);
    checkOutput("rst_valid", {31'b0, valid_a}, 32'h0);
    checkOutput("rst_instr", instr_a, 32'h0);
    checkOutput("rst_stall_cnt", {16'b0, scnt_a}, 32'h0);
    checkOutput("rst_bubble", {31'b0, bubble_a}, 32'h0);
    checkOutput("rst_halted", {31'b0, halted_a}, 32'h0);

    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("free_pc4", pc_a, 32'h4);
    checkOutput("free_instr", instr_a, 32'h8C220004);
    checkOutput("free_valid", {31'b0, valid_a}, 32'h1);
    tick();
    checkOutput("free_pc8", pc_a, 32'h8);

    applyStimulus(0, 1, 0, 0, 32'h0, 0);
    #1 checkOutput("stall_bubble", {31'b0, bubble_a}, 32'h1);
    tick();
    checkOutput("stall_pc1", pc_a, 32'h8);
    tick();
    checkOutput("stall_pc2", pc_a, 32'h8);
    checkOutput("stall_cnt2", {16'b0, scnt_a}, 32'd2);
    checkOutput("stall_ifid_pc4", pc4_a, 32'h8);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("release_pc", pc_a, 32'hC);
    tick();

    applyStimulus(0, 0, 0, 1, 32'h40, 0);
    tick();
    checkOutput("br_pc", pc_a, 32'h40);
    checkOutput("br_instr", instr_a, 32'h0);
    checkOutput("br_valid", {31'b0, valid_a}, 32'h0);
    checkOutput("br_flush_cnt", {16'b0, fcnt_a}, 32'd1);

    applyStimulus(0, 1, 0, 1, 32'h80, 0);
    tick();
    checkOutput("stallbr_pc", pc_a, 32'h40);
    checkOutput("stallbr_stall_cnt", {16'b0, scnt_a}, 32'd3);
    checkOutput("stallbr_flush_cnt", {16'b0, fcnt_a}, 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h80, 0);
    tick();
    checkOutput("rebr_pc", pc_a, 32'h80);

    applyStimulus(0, 0, 0, 1, 32'h20, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    tick();
    checkOutput("halt_halted", {31'b0, halted_a}, 32'h1);
    checkOutput("halt_pc", pc_a, 32'h20);
    checkOutput("halt_valid", {31'b0, valid_a}, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'h100, 0);
    #1 checkOutput("halt_bubble", {31'b0, bubble_a}, 32'h0);
    tick();
    checkOutput("halt_frozen_pc", pc_a, 32'h20);
    checkOutput("halt_frozen_stall", {16'b0, scnt_a}, 32'd3);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("unhalt_pc", pc_a, 32'h0);
    checkOutput("unhalt_halted", {31'b0, halted_a}, 32'h0);

    applyStimulus(0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("sat_small", {30'b0, scnt_b}, exp_sat[i]);
    end

    applyStimulus(0, 0, 0, 1, 32'hFFFFFFFC, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("wrap_pc", pc_a, 32'h0);
    checkOutput("wrap_pc4", pc4_a, 32'h0);

    const_mode = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] tgt;
      r = $urandom_range(0, 99);
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC)) : $urandom;
      applyStimulus((r < 2) || (m_halted && r < 15),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0,
                    tgt,
                    $urandom_range(0, 99) < 3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/if_id_stage_ctrl.md
Name: if_id_stage_ctrl

Overview:
Front-end pipeline control that acts on the stall/flush requests raised by the ID-stage hazard unit. It owns the PC register and the IF/ID pipeline register. It holds them on a stall, redirects and flushes on a taken branch, and generates the bubble strobe for the ID/EX register. It also keeps saturating stall and flush counters and a sticky halt state for the debug unit.

Parameters:
PC_W, 32, PC and branch-target width
INSTR_W, 32, instruction width
CNT_W, 16, width of each performance counter
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  load-use stall request from hazard unit
flush_idex  in  1  ID/EX flush request from hazard unit
branch_taken  in  1  branch resolved taken in ID
branch_target  in  PC_W  redirect address
halt  in  1  halt request (HALT decode or debug)
imem_instr  in  INSTR_W  instruction memory read data for pc_out (combinational read)
pc_out  out  PC_W  current PC; instruction memory address
if_id_instr  out  INSTR_W  IF/ID instruction
if_id_pc_plus4  out  PC_W  IF/ID PC+4
if_id_valid  out  1  IF/ID slot holds a real instruction
idex_bubble  out  1  ID/EX must load zero controls at the next edge (combinational)
stall_cnt  out  CNT_W  stall cycles, saturating
flush_cnt  out  CNT_W  flush events, saturating
halted  out  1  sticky halt state

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high (reset). It has priority over everything else.
- Reset values:
  - pc_out = RESET_PC
  - if_id_instr = 0 (NOP)
  - if_id_pc_plus4 = 0
  - if_id_valid = 0
  - stall_cnt = 0, flush_cnt = 0
  - halted = 0
  - idex_bubble evaluates to 0 while reset is high.
- Per-edge priority, after reset: halted > stall > branch_taken > halt > normal.
- RUN state (halted=0):
  - Normal:
    - pc <= pc+4
    - if_id_instr <= imem_instr
    - if_id_pc_plus4 <= pc+4
    - if_id_valid <= 1
  - stall=1:
    - PC and all IF/ID fields hold.
    - branch_taken and halt are ignored that cycle. The branch is re-resolved next cycle from the held IF/ID.
  - branch_taken=1, stall=0:
    - pc <= branch_target
    - if_id_instr <= 0
    - if_id_valid <= 0
    - if_id_pc_plus4 <= 0
    - This gives one-slot flush latency; the first target instruction is in IF/ID two edges after branch_taken.
  - halt=1, stall=0, branch_taken=0:
    - halted <= 1
    - PC holds
    - IF/ID loads NOP with valid=0
- HALTED state:
  - PC and IF/ID frozen; all inputs ignored; counters frozen.
  - Exit only via reset.
- idex_bubble = (stall | flush_idex) & ~halted & ~reset. stall and flush_idex together produce one bubble with stall semantics.
- stall_cnt: +1 on each edge with stall=1 in RUN. Holds at 2^CNT_W-1 (no wrap).
- flush_cnt: +1 on each edge in RUN where an accepted branch_taken or flush_idex is present. Simultaneous branch_taken and flush_idex count once. Saturating.
- pc+4 wraps modulo 2^PC_W. A branch_target is used as given; no alignment check.
- Reset asserted mid-stall or mid-halt: the next edge yields the reset values; no residual hold.

Decomposition:
- Shared pipeline package:
  - NOP_INSTR constant (all zeros)
  - PC_INCR constant (4)
  - shared width constants PC_W / INSTR_W
  - RUN/HALTED state encoding
- One sub-module: sat_counter, parameterised by width, with inc enable and synchronous reset. It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset then 3 free cycles with imem_instr=0x8C220004 → pc_out 0x0,0x4,0x8,0xC; if_id_instr=0x8C220004; if_id_valid=1; counters 0.
- stall=1 for 2 cycles at pc=0x8 → pc_out stays 0x8, IF/ID unchanged, idex_bubble=1 both cycles, stall_cnt=2; pc_out=0xC after release.
- branch_taken=1, branch_target=0x40 at pc=0x10 → next edge pc_out=0x40, if_id_instr=0, if_id_valid=0, flush_cnt=1.
- stall=1 with branch_taken=1 and target 0x80 → PC/IF/ID hold, no redirect, stall_cnt+1, flush_cnt unchanged; branch_taken next cycle alone → pc_out=0x80.
- halt=1 at pc=0x20 → halted=1, pc_out frozen at 0x20, if_id_valid=0; later stall/branch have no effect and idex_bubble=0; reset → pc_out=RESET_PC, halted=0.
- CNT_W=2, stall held 5 cycles → stall_cnt 1,2,3,3,3 (saturates, no wrap).
